// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam int FLAGS_W = 4;

    // Bit positions of {N,Z,C,V} within the flags vector.
    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a debounced, synchronised button level.
// History resets to 1 so a button held through reset release is not a press.
module btn_edge_detect (
    input  logic CLK100MHZ,
    input  logic CPU_RESET,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET)
            btn_q <= 1'b1;
        else
            btn_q <= btn;
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Captures A, B and opcode from the switches, launches the ALU and holds its result.
// Build option: RESULT_CHAIN_EN makes advance in SHOW load the result into op_a.
//
// state   | meaning
// LOAD_A  | waiting for operand A
// LOAD_B  | waiting for operand B
// LOAD_OP | waiting for opcode
// EXEC    | ALU launched, waiting for alu_done or timeout
// SHOW    | result and flags held for display
// ERR     | ALU timed out, err held until advance
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N_BITS  = 8,
    parameter int OP_BITS = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESET,
    input  logic                 BTNC,
    input  logic                 BTND,
    input  logic [N_BITS-1:0]    SW,
    input  logic                 alu_done,
    input  logic [N_BITS-1:0]    alu_result,
    input  logic [FLAGS_W-1:0]   alu_flags,
    output logic [N_BITS-1:0]    op_a,
    output logic [N_BITS-1:0]    op_b,
    output logic [OP_BITS-1:0]   opcode,
    output logic                 alu_start,
    output logic [N_BITS-1:0]    result,
    output logic [FLAGS_W-1:0]   flags,
    output logic [2:0]           c_state,
    output logic                 err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               raw_c;
    logic               raw_d;
    logic               press_c;
    logic               press_d;

    btn_edge_detect u_edge_c (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESET (CPU_RESET),
        .btn       (BTNC),
        .press     (raw_c)
    );

    btn_edge_detect u_edge_d (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESET (CPU_RESET),
        .btn       (BTND),
        .press     (raw_d)
    );

    // Simultaneous advance and back cancel each other.
    assign press_c = raw_c & ~raw_d;
    assign press_d = raw_d & ~raw_c;

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            state     <= LOAD_A;
            op_a      <= '0;
            op_b      <= '0;
            opcode    <= '0;
            result    <= '0;
            flags     <= '0;
            cnt       <= '0;
            alu_start <= 1'b0;
            err       <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (press_c) begin
                        op_a  <= SW;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press_c) begin
                        op_b  <= SW;
                        state <= LOAD_OP;
                    end else if (press_d) begin
                        state <= LOAD_A;
                    end
                end
                LOAD_OP: begin
                    if (press_c) begin
                        opcode    <= SW[OP_BITS-1:0];
                        cnt       <= '0;
                        alu_start <= 1'b1;
                        state     <= EXEC;
                    end else if (press_d) begin
                        state <= LOAD_B;
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        result <= alu_result;
                        flags  <= alu_flags;
                        state  <= SHOW;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (press_c) begin
`ifdef RESULT_CHAIN_EN
                        op_a  <= result;
                        state <= LOAD_B;
`else
                        state <= LOAD_A;
`endif
                    end else if (press_d) begin
                        state <= LOAD_OP;
                    end
                end
                ERR: begin
                    if (press_c) begin
                        err   <= 1'b0;
                        state <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign c_state = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; honours RESULT_CHAIN_EN when defined.
module tb_alu_op_sequencer;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESET = 1'b1;
    logic       BTNC = 1'b0;
    logic       BTND = 1'b0;
    logic [7:0] SW = 8'h00;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic [3:0] alu_flags = 4'h0;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] opcode;
    logic       alu_start;
    logic [7:0] result;
    logic [3:0] flags;
    logic [2:0] c_state;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int snap;
    int n_exec;

    alu_op_sequencer #(.N_BITS(8), .OP_BITS(2), .TIMEOUT(16)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESET  (CPU_RESET),
        .BTNC       (BTNC),
        .BTND       (BTND),
        .SW         (SW),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .op_a       (op_a),
        .op_b       (op_b),
        .opcode     (opcode),
        .alu_start  (alu_start),
        .result     (result),
        .flags      (flags),
        .c_state    (c_state),
        .err        (err)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(negedge CLK100MHZ) if (alu_start) n_start++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic press_c(input logic [7:0] v);
        SW = v;
        BTNC = 1'b1;
        step();
        BTNC = 1'b0;
        step();
    endtask

    task automatic press_d();
        BTND = 1'b1;
        step();
        BTND = 1'b0;
        step();
    endtask

    initial begin
        // reset state
        step(); step();
        check("rst_state", c_state, 0);
        check("rst_opa", op_a, 0);
        check("rst_start", alu_start, 0);
        check("rst_err", err, 0);
        CPU_RESET = 1'b0;
        step();

        // load A, B, opcode and launch
        press_c(8'h05);
        check("load_a_state", c_state, 1);
        check("load_a_val", op_a, 8'h05);
        press_c(8'h03);
        check("load_b_state", c_state, 2);
        check("load_b_val", op_b, 8'h03);
        SW = 8'h01; BTNC = 1'b1;
        step();
        BTNC = 1'b0;
        check("exec_state", c_state, 3);
        check("exec_start1", alu_start, 1);
        check("exec_opcode", opcode, 1);
        step();
        check("exec_start2", alu_start, 0);
        step();
        alu_done = 1'b1; alu_result = 8'h08; alu_flags = 4'b0000;
        step();
        check("show_state", c_state, 4);
        check("show_result", result, 8'h08);
        check("show_flags", flags, 4'b0000);
        check("start_count1", n_start, 1);
        for (int i = 0; i < 4; i++) begin
            alu_done = i[0]; alu_result = 8'hA0 + 8'(i); alu_flags = 4'(i + 5);
            step();
        end
        alu_done = 1'b0;
        check("show_hold_result", result, 8'h08);
        check("show_hold_flags", flags, 4'b0000);
        check("show_hold_state", c_state, 4);

        // re-execute with new opcode, done on the start cycle
        press_d();
        check("show_back_state", c_state, 2);
        SW = 8'h02; BTNC = 1'b1;
        step();
        BTNC = 1'b0;
        check("reexec_state", c_state, 3);
        alu_done = 1'b1; alu_result = 8'h80; alu_flags = 4'b1000;
        step();
        alu_done = 1'b0;
        check("reexec_show", c_state, 4);
        check("reexec_result", result, 8'h80);
        check("reexec_flags", flags, 4'b1000);
        check("reexec_opcode", opcode, 2);
        press_c(8'hFF);
`ifdef RESULT_CHAIN_EN
        check("chain_state", c_state, 1);
        check("chain_opa", op_a, 8'h80);
`else
        check("nochain_state", c_state, 0);
        check("nochain_opa", op_a, 8'h05);
`endif
        press_d();
        check("common_state", c_state, 0);

        // timeout
        press_c(8'h11);
        press_c(8'h22);
        SW = 8'h03; BTNC = 1'b1;
        step();
        BTNC = 1'b0;
        n_exec = 0;
        for (int i = 0; i < 40 && c_state == 3'd3; i++) begin
            n_exec++;
            step();
        end
        check("timeout_cycles", n_exec, 16);
        check("timeout_state", c_state, 5);
        check("timeout_err", err, 1);
        check("timeout_result", result, 8'h80);
        check("timeout_flags", flags, 4'b1000);
        alu_done = 1'b1; alu_result = 8'h33;
        step();
        alu_done = 1'b0;
        check("late_done_state", c_state, 5);
        check("late_done_result", result, 8'h80);
        press_d();
        check("err_d_ignored", c_state, 5);
        press_c(8'h00);
        check("err_clear_state", c_state, 0);
        check("err_clear_err", err, 0);

        // simultaneous buttons, back from LOAD_B, held button
        press_c(8'h44);
        check("simul_pre", c_state, 1);
        BTNC = 1'b1; BTND = 1'b1;
        step();
        check("simul_state", c_state, 1);
        BTNC = 1'b0; BTND = 1'b0;
        step();
        press_d();
        check("back_state", c_state, 0);
        check("back_opa", op_a, 8'h44);
        SW = 8'h55; BTNC = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("hold_state", c_state, 1);
        check("hold_opa", op_a, 8'h55);
        BTNC = 1'b0;
        step();
        press_d();

        // button held across reset release
        BTNC = 1'b1; CPU_RESET = 1'b1;
        step();
        CPU_RESET = 1'b0;
        step(); step(); step();
        check("held_reset_state", c_state, 0);
        check("held_reset_opa", op_a, 0);
        BTNC = 1'b0;
        step();

        // reset mid-EXEC
        press_c(8'h12);
        press_c(8'h34);
        SW = 8'h01; BTNC = 1'b1;
        step();
        BTNC = 1'b0;
        step();
        check("mid_exec_state", c_state, 3);
        snap = n_start;
        #2;
        CPU_RESET = 1'b1;
        #1;
        check("async_state", c_state, 0);
        check("async_opa", op_a, 0);
        check("async_opb", op_b, 0);
        check("async_opcode", opcode, 0);
        check("async_result", result, 0);
        check("async_flags", flags, 0);
        check("async_start", alu_start, 0);
        check("async_err", err, 0);
        step(); step();
        CPU_RESET = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("no_restart", n_start - snap, 0);
        check("post_reset_state", c_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
